mvm_pp_sched: RTL

Ping-pong buffer scheduler for the matrix-vector multiplier datapath. It owns the two memory banks (bank 0 "ping", bank 1 "pong") that sit between the 8-bit input stream and the MAC array, and it sequences them. It generates write enables and addresses for the bank being filled, and read sweeps for the bank being consumed. It tracks how many banks hold unconsumed data and applies back-pressure to the input stream. It stands alone in front of the existing `memory` instances and `part3_mac` array, replacing ad-hoc pointer logic in the top level.

---
 rtl/mvm_pp_sched.sv | 97 +++++++++
 1 files changed

// File: rtl/mvm_pp_sched.sv
// Ping-pong bank scheduler: fills one bank from the input stream while the MAC
// array sweeps the other, with back-pressure once both banks hold data.
module mvm_pp_sched #(
  parameter int DEPTH    = 16,
  parameter int LOGDEPTH = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                wr_en,
  output logic                wr_bank,
  output logic [LOGDEPTH-1:0] wr_addr,
  input  logic                rd_stall,
  output logic                rd_en,
  output logic                rd_bank,
  output logic [LOGDEPTH-1:0] rd_addr,
  output logic                rd_last,
  output logic                rd_dvalid,
  input  logic                rd_release,
  output logic [1:0]          full_cnt,
  output logic                proto_err
);

  typedef enum logic [1:0] {R_IDLE, R_SWEEP, R_WAIT_REL} rstate_t;

  localparam logic [LOGDEPTH-1:0] LAST = LOGDEPTH'(DEPTH - 1);

  rstate_t state;
  logic    fill_done;
  logic    rel_evt;

  assign s_ready   = (full_cnt != 2'd2);
  assign wr_en     = s_valid & s_ready;
  assign fill_done = wr_en && (wr_addr == LAST);
  assign rd_en     = (state == R_SWEEP) && !rd_stall;
  assign rd_last   = rd_en && (rd_addr == LAST);
  // A release only counts while a swept bank is waiting to be handed back.
  assign rel_evt   = rd_release && (state == R_WAIT_REL);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr   <= '0;
      wr_bank   <= 1'b0;
      rd_addr   <= '0;
      rd_bank   <= 1'b0;
      full_cnt  <= 2'd0;
      state     <= R_IDLE;
      rd_dvalid <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      rd_dvalid <= rd_en;

      if (wr_en) begin
        if (fill_done) begin
          wr_addr <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end

      if (fill_done && !rel_evt)
        full_cnt <= full_cnt + 2'd1;
      else if (rel_evt && !fill_done)
        full_cnt <= full_cnt - 2'd1;

      if (rd_release && !rel_evt)
        proto_err <= 1'b1;

      case (state)
        R_IDLE: begin
          rd_addr <= '0;
          if (full_cnt != 2'd0) state <= R_SWEEP;
        end
        R_SWEEP: begin
          if (rd_en) begin
            if (rd_addr == LAST) begin
              rd_addr <= '0;
              state   <= R_WAIT_REL;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end
        R_WAIT_REL: begin
          if (rd_release) begin
            rd_bank <= ~rd_bank;
            state   <= R_IDLE;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule
